dice_roller: RTL and testbench

Consumes the free-running 8-bit pseudo-random byte from the game's random number generator and turns it into a uniform die face in 1..SIDES on request. Uses rejection sampling with a bounded retry count. It sits between the RNG and the game-logic FSM, which issues roll requests and takes results through a valid/ready handshake. A saturating roll counter is provided for debug and score-screen use.

---
 rtl/game_pkg.sv | 19 +
 rtl/dice_roller_if.sv | 23 ++
 rtl/dice_roller_range_reduce.sv | 21 ++
 rtl/dice_roller.sv | 98 +++++++++
 tb/tb_dice_roller.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game types and constants: bus widths, die FSM states, rejection limit.
package game_pkg;

    localparam int unsigned RAND_W = 8;
    localparam int unsigned TRY_W  = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Largest multiple of sides that fits in one byte's range; samples below it are unbiased.
    function automatic int unsigned calc_limit(input int unsigned sides);
        return 32'd256 - (32'd256 % sides);
    endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Roll request / result handshake between the game-logic FSM and the dice roller.
interface dice_roller_if;
    import game_pkg::*;

    logic              roll_req;
    logic              busy;
    logic              result_valid;
    logic              result_ready;
    logic [RAND_W-1:0] result;
    logic              biased;
    logic [CNT_W-1:0]  roll_count;

    modport master (
        output roll_req, result_ready,
        input  busy, result_valid, result, biased, roll_count
    );

    modport slave (
        input  roll_req, result_ready,
        output busy, result_valid, result, biased, roll_count
    );

endinterface

// File: rtl/dice_roller_range_reduce.sv
// Static reduction of one random byte to a die face plus an unbiased-sample flag.
module range_reduce
    import game_pkg::*;
#(
    parameter int unsigned SIDES = 6
) (
    input  logic [RAND_W-1:0] sample_i,
    output logic [RAND_W-1:0] face_o,
    output logic              accept_o
);

    localparam int unsigned LIMIT = calc_limit(SIDES);
    localparam int unsigned LIM_W = RAND_W + 1;

    // LIMIT can be 256 for power-of-two dice, so compare one bit wider.
    always_comb begin
        face_o   = RAND_W'((32'(sample_i) % SIDES) + 32'd1);
        accept_o = (LIM_W'(sample_i) < LIM_W'(LIMIT));
    end

endmodule

// File: rtl/dice_roller.sv
// Rejection-sampling die roller with bounded retries and a saturating roll counter.
module dice_roller
    import game_pkg::*;
#(
    parameter int unsigned SIDES     = 6,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RAND_W-1:0] random_number,
    dice_roller_if.slave      bus
);

    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic [TRY_W-1:0]  try_q, try_d;
    logic [RAND_W-1:0] result_q, result_d;
    logic              biased_q, biased_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [RAND_W-1:0] face;
    logic              accept;

    range_reduce #(.SIDES(SIDES)) u_reduce (
        .sample_i (random_number),
        .face_o   (face),
        .accept_o (accept)
    );

    // Next-state: sample until accept or retry budget spent, then hold until handshake.
    always_comb begin
        state_d  = state_q;
        try_d    = try_q;
        result_d = result_q;
        biased_d = biased_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.roll_req) begin
                    state_d = ST_SAMPLE;
                    try_d   = '0;
                end
            end
            ST_SAMPLE: begin
                if (accept) begin
                    result_d = face;
                    biased_d = 1'b0;
                    state_d  = ST_HOLD;
                end else if (try_q == LAST_TRY) begin
                    result_d = face;
                    biased_d = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.result_ready) begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (bus.roll_req) begin
                        state_d = ST_SAMPLE;
                        try_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            try_q    <= '0;
            result_q <= '0;
            biased_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            try_q    <= try_d;
            result_q <= result_d;
            biased_q <= biased_d;
            count_q  <= count_d;
        end
    end

    assign bus.busy         = (state_q == ST_SAMPLE);
    assign bus.result_valid = (state_q == ST_HOLD);
    assign bus.result       = result_q;
    assign bus.biased       = biased_q;
    assign bus.roll_count   = count_q;

endmodule

// File: tb/tb_dice_roller.sv
// Randomized bench for dice_roller against a per-roll reference model.
module tb_dice_roller;
    import game_pkg::*;

    localparam int unsigned SIDES     = 6;
    localparam int unsigned MAX_TRIES = 8;
    localparam int unsigned LIMIT_M   = 256 - (256 % SIDES);

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] random_number;

    dice_roller_if bus();

    dice_roller #(.SIDES(SIDES), .MAX_TRIES(MAX_TRIES)) dut (
        .clk           (clk),
        .reset         (reset),
        .random_number (random_number),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         exp_count;
    logic [7:0] exp_face;
    logic       exp_biased;
    logic [7:0] rseq [1:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int c = 1; c <= 15; c++) rseq[c] = v;
    endtask

    task automatic fill_random();
        for (int c = 1; c <= 15; c++)
            rseq[c] = ($urandom_range(0, 9) < 4) ? 8'(252 + $urandom_range(0, 3))
                                                 : 8'($urandom_range(0, 251));
    endtask

    // First in-range sample wins; otherwise the last allowed sample is taken, flagged biased.
    task automatic model_roll(output int k, output logic [7:0] f, output logic b);
        k = MAX_TRIES;
        b = 1'b1;
        for (int c = 1; c <= int'(MAX_TRIES); c++) begin
            if (int'(rseq[c]) < int'(LIMIT_M)) begin
                k = c;
                b = 1'b0;
                break;
            end
        end
        f = 8'((int'(rseq[k]) % SIDES) + 1);
    endtask

    task automatic start_roll();
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_valid", 32'(bus.result_valid), 32'd0);
        bus.roll_req     = 1'b1;
        bus.result_ready = 1'($urandom_range(0, 1));
        random_number    = 8'($urandom);
    endtask

    // Called at the negedge of the request cycle; returns at the negedge of the first HOLD cycle.
    task automatic sample_and_check();
        int k;
        model_roll(k, exp_face, exp_biased);
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            check("samp_busy", 32'(bus.busy), 32'd1);
            check("samp_valid", 32'(bus.result_valid), 32'd0);
            check("samp_cnt", 32'(bus.roll_count), 32'(exp_count));
            bus.roll_req     = 1'($urandom_range(0, 1));
            bus.result_ready = 1'($urandom_range(0, 1));
            random_number    = rseq[c];
        end
        @(negedge clk);
        check("res_valid", 32'(bus.result_valid), 32'd1);
        check("res_busy", 32'(bus.busy), 32'd0);
        check("res_face", 32'(bus.result), 32'(exp_face));
        check("res_biased", 32'(bus.biased), 32'(exp_biased));
        check("res_cnt", 32'(bus.roll_count), 32'(exp_count));
    endtask

    task automatic hold_and_accept(input int n, input bit chain);
        for (int i = 0; i < n; i++) begin
            bus.result_ready = 1'b0;
            bus.roll_req     = 1'($urandom_range(0, 1));
            random_number    = 8'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(bus.result_valid), 32'd1);
            check("hold_face", 32'(bus.result), 32'(exp_face));
            check("hold_biased", 32'(bus.biased), 32'(exp_biased));
            check("hold_cnt", 32'(bus.roll_count), 32'(exp_count));
        end
        bus.result_ready = 1'b1;
        bus.roll_req     = chain;
        random_number    = 8'($urandom);
        if (exp_count != 32'hFFFF) exp_count++;
        if (!chain) begin
            @(negedge clk);
            check("done_valid", 32'(bus.result_valid), 32'd0);
            check("done_busy", 32'(bus.busy), 32'd0);
            check("done_cnt", 32'(bus.roll_count), 32'(exp_count));
            bus.roll_req     = 1'b0;
            bus.result_ready = 1'b0;
        end
    endtask

    task automatic directed_roll(input string tag, input logic [7:0] face, input logic b);
        start_roll();
        sample_and_check();
        check({tag, "_face"}, 32'(bus.result), 32'(face));
        check({tag, "_biased"}, 32'(bus.biased), 32'(b));
        hold_and_accept(1, 1'b0);
    endtask

    initial begin
        bit chained;
        reset            = 1'b1;
        bus.roll_req     = 1'b0;
        bus.result_ready = 1'b0;
        random_number    = 8'd0;
        exp_count        = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_face", 32'(bus.result), 32'd0);
        check("rst_biased", 32'(bus.biased), 32'd0);
        check("rst_cnt", 32'(bus.roll_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        fill_const(8'd13);
        directed_roll("acc13", 8'd2, 1'b0);
        fill_const(8'd251);
        directed_roll("acc251", 8'd6, 1'b0);
        for (int c = 1; c <= 15; c++) rseq[c] = (c <= 3) ? 8'd252 : 8'd0;
        directed_roll("rej3", 8'd1, 1'b0);
        fill_const(8'd255);
        directed_roll("fallback", 8'd4, 1'b1);

        // Long backpressure, then handshake with a chained request.
        fill_random();
        start_roll();
        sample_and_check();
        hold_and_accept(10, 1'b1);
        fill_random();
        sample_and_check();
        hold_and_accept(0, 1'b0);

        chained = 1'b0;
        for (int r = 0; r < 40; r++) begin
            fill_random();
            if (!chained) start_roll();
            sample_and_check();
            chained = 1'($urandom_range(0, 1));
            hold_and_accept(int'($urandom_range(0, 3)), chained);
        end
        if (chained) begin
            fill_random();
            sample_and_check();
            hold_and_accept(0, 1'b0);
        end

        // Counter saturation from a preloaded value.
        force dut.count_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.count_q;
        exp_count = 32'hFFFE;
        @(negedge clk);
        check("sat_preload", 32'(bus.roll_count), 32'hFFFE);
        for (int r = 0; r < 3; r++) begin
            fill_random();
            start_roll();
            sample_and_check();
            hold_and_accept(1, 1'b0);
        end
        check("sat_final", 32'(bus.roll_count), 32'hFFFF);

        // Asynchronous reset in the middle of sampling.
        fill_const(8'd255);
        start_roll();
        @(negedge clk);
        random_number = 8'd255;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_valid", 32'(bus.result_valid), 32'd0);
        check("arst_face", 32'(bus.result), 32'd0);
        check("arst_biased", 32'(bus.biased), 32'd0);
        check("arst_cnt", 32'(bus.roll_count), 32'd0);
        exp_count        = 0;
        bus.roll_req     = 1'b0;
        bus.result_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        fill_random();
        start_roll();
        sample_and_check();
        hold_and_accept(2, 1'b0);
        check("post_rst_cnt", 32'(bus.roll_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
